lfsr_keystream_ctrl: RTL and testbench

LFSR_KEYSTREAM_CTRL -- requirements
Module: lfsr_keystream_ctrl

---
 rtl/lfsr_keystream_ctrl_if.sv | 31 +++
 rtl/lfsr_keystream_ctrl.sv | 109 ++++++++++
 tb/tb_lfsr_keystream_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/lfsr_keystream_ctrl_if.sv
// lfsr_keystream_ctrl_if
//   Control/handshake bundle for lfsr_keystream_ctrl.
//   master : session controller and requesters (drives i_*, observes o_*)
//   slave  : lfsr_keystream_ctrl (observes i_*, drives o_*)
//   i_start   session start pulse           i_stop    abort session
//   i_seed    4-bit LFSR seed (nonzero)     i_warmup  keystream bits to discard
//   i_req     per-requester byte request    o_byte    assembled keystream byte
//   o_valid   byte available                o_gnt     one-hot grant
//   o_busy    not in IDLE                   o_err     sticky zero-seed error
interface lfsr_keystream_ctrl_if;
    logic       i_start;
    logic       i_stop;
    logic [3:0] i_seed;
    logic [7:0] i_warmup;
    logic [1:0] i_req;
    logic [7:0] o_byte;
    logic       o_valid;
    logic [1:0] o_gnt;
    logic       o_busy;
    logic       o_err;

    modport master (
        output i_start, i_stop, i_seed, i_warmup, i_req,
        input  o_byte, o_valid, o_gnt, o_busy, o_err
    );

    modport slave (
        input  i_start, i_stop, i_seed, i_warmup, i_req,
        output o_byte, o_valid, o_gnt, o_busy, o_err
    );
endinterface

// File: rtl/lfsr_keystream_ctrl.sv
// lfsr_keystream_ctrl
//   Seeds a free-running 4-bit LFSR, discards a programmable number of warm-up
//   bits, assembles keystream bytes LSB-first and hands each byte to one of two
//   requesters through a round-robin grant.
//   i_clk         clock, rising edge
//   i_reset       synchronous active-high reset
//   i_keystream   keystream bit from the LFSR
//   o_lfsr_reset  seed-load strobe to the LFSR (one cycle per session)
//   o_lfsr_seed   registered seed presented to the LFSR
//   bus           session control, requests, byte output and status
module lfsr_keystream_ctrl (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_keystream,
    output logic       o_lfsr_reset,
    output logic [3:0] o_lfsr_seed,
    lfsr_keystream_ctrl_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WARM  = 3'd2;
    localparam logic [2:0] S_FILL  = 3'd3;
    localparam logic [2:0] S_OFFER = 3'd4;

    logic [2:0] r_state;
    logic [7:0] r_warm;
    logic [6:0] r_shift;
    logic [2:0] r_bitcnt;
    logic       r_last;     // index of the requester granted most recently
    logic [1:0] w_gnt;
    logic       w_xfer;

    // Grant only in OFFER; a concurrent stop suppresses the transfer.
    always_comb begin
        w_gnt = '0;
        if (r_state == S_OFFER && !bus.i_stop) begin
            case (bus.i_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
                default: w_gnt = '0;
            endcase
        end
    end

    assign bus.o_gnt   = w_gnt;
    assign bus.o_valid = (r_state == S_OFFER);
    assign bus.o_busy  = (r_state != S_IDLE);
    assign o_lfsr_reset = (r_state == S_LOAD);
    assign w_xfer      = bus.o_valid & (|w_gnt);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            o_lfsr_seed <= '0;
            bus.o_byte  <= '0;
            bus.o_err   <= 1'b0;
            r_warm      <= '0;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_last      <= 1'b1;
        end else if (r_state != S_IDLE && bus.i_stop) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start && !bus.i_stop) begin
                        if (bus.i_seed != 4'd0) begin
                            o_lfsr_seed <= bus.i_seed;
                            r_warm      <= bus.i_warmup;
                            bus.o_err   <= 1'b0;
                            r_state     <= S_LOAD;
                        end else begin
                            bus.o_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    // Clearing here discards any partial byte left by a stop.
                    r_bitcnt <= '0;
                    r_state  <= (r_warm != 8'd0) ? S_WARM : S_FILL;
                end
                S_WARM: begin
                    r_warm <= r_warm - 8'd1;
                    if (r_warm == 8'd1) r_state <= S_FILL;
                end
                S_FILL: begin
                    // New bit enters at the top so the first sample ends in bit 0.
                    r_shift  <= {i_keystream, r_shift[6:1]};
                    r_bitcnt <= r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        bus.o_byte <= {i_keystream, r_shift};
                        r_state    <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    // Keystream bits arriving here are dropped; counter already wrapped to 0.
                    if (w_xfer) begin
                        r_last  <= w_gnt[1];
                        r_state <= S_FILL;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_keystream_ctrl.sv
module tb_lfsr_keystream_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ks;
    logic       lfsr_reset;
    logic [3:0] lfsr_seed;
    int         n_checks = 0;
    int         n_errors = 0;

    lfsr_keystream_ctrl_if bus ();

    lfsr_keystream_ctrl dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_keystream  (ks),
        .o_lfsr_reset (lfsr_reset),
        .o_lfsr_seed  (lfsr_seed),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one keystream bit, advance one rising edge, settle.
    task automatic step(input logic b);
        ks = b;
        @(posedge clk);
        #1;
    endtask

    // Feed 8 bits LSB-first from FILL; o_valid must rise exactly on the 8th edge.
    task automatic fill_byte(input string tag, input logic [7:0] bits, input logic [7:0] exp);
        for (int i = 0; i < 8; i++) begin
            step(bits[i]);
            if (i == 6) check_eq({tag, "_valid_early"}, bus.o_valid, 1'b0);
        end
        check_eq({tag, "_valid"}, bus.o_valid, 1'b1);
        check_eq({tag, "_byte"}, bus.o_byte, exp);
    endtask

    logic [7:0] pats [4];

    initial begin
        pats = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
        rst = 1'b1; ks = 1'b0;
        bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_seed = '0;
        bus.i_warmup = '0; bus.i_req = '0;
        step(0); step(0);
        check_eq("rst_valid", bus.o_valid, 0);
        check_eq("rst_busy", bus.o_busy, 0);
        check_eq("rst_err", bus.o_err, 0);
        check_eq("rst_seed", lfsr_seed, 0);
        check_eq("rst_byte", bus.o_byte, 0);
        check_eq("rst_lfsr_reset", lfsr_reset, 0);
        rst = 1'b0;

        // Session 1: seed 9, no warm-up, bits 1,0,1,1,0,0,1,0 -> 8'h4D at N+9
        bus.i_seed = 4'h9; bus.i_warmup = 8'd0; bus.i_start = 1'b1;
        step(1);                                        // edge N
        bus.i_start = 1'b0;
        check_eq("t1_lfsr_reset_on", lfsr_reset, 1);
        check_eq("t1_seed", lfsr_seed, 4'h9);
        check_eq("t1_busy", bus.o_busy, 1);
        step(1);                                        // edge N+1, LOAD->FILL
        check_eq("t1_lfsr_reset_off", lfsr_reset, 0);
        fill_byte("t1", 8'b0100_1101, 8'h4D);           // edges N+2..N+9
        for (int i = 0; i < 3; i++) begin
            step(i[0]);
            check_eq("t1_hold_valid", bus.o_valid, 1);
            check_eq("t1_hold_byte", bus.o_byte, 8'h4D);
        end
        check_eq("t1_nogrant", bus.o_gnt, 2'b00);
        bus.i_req = 2'b10; #1;
        check_eq("t1_gnt_req1", bus.o_gnt, 2'b10);
        step(0);                                        // transfer
        bus.i_req = 2'b00;
        check_eq("t1_valid_drop", bus.o_valid, 0);
        fill_byte("t1b", 8'hC3, 8'hC3);
        bus.i_stop = 1'b1;
        step(0);
        bus.i_stop = 1'b0;
        check_eq("t1_stop_busy", bus.o_busy, 0);

        // Session 2: warm-up 3, warm bits are 1s and must not appear in the byte
        bus.i_seed = 4'hA; bus.i_warmup = 8'd3; bus.i_start = 1'b1;
        step(1);                                        // edge N
        bus.i_start = 1'b0;
        step(1);                                        // N+1 -> WARM
        bus.i_start = 1'b1; bus.i_seed = 4'h0;          // ignored outside IDLE
        step(1);                                        // N+2
        bus.i_start = 1'b0; bus.i_seed = 4'hA;
        check_eq("t2_start_ignored_err", bus.o_err, 0);
        step(1); step(1);                               // N+3, N+4
        fill_byte("t2", 8'b0001_0110, 8'h16);           // valid at N+12
        bus.i_stop = 1'b1;
        step(0);
        bus.i_stop = 1'b0;

        // Zero seed: error, no session, seed register untouched
        bus.i_seed = 4'h0; bus.i_start = 1'b1;
        step(0);
        bus.i_start = 1'b0;
        check_eq("t3_err", bus.o_err, 1);
        check_eq("t3_busy", bus.o_busy, 0);
        check_eq("t3_lfsr_reset", lfsr_reset, 0);
        check_eq("t3_seed_kept", lfsr_seed, 4'hA);
        step(0);
        check_eq("t3_lfsr_reset2", lfsr_reset, 0);
        // Stop wins over start in IDLE
        bus.i_seed = 4'h7; bus.i_start = 1'b1; bus.i_stop = 1'b1;
        step(0);
        bus.i_start = 1'b0; bus.i_stop = 1'b0;
        check_eq("t3_stop_prio_busy", bus.o_busy, 0);
        check_eq("t3_stop_prio_seed", lfsr_seed, 4'hA);

        // Session 4: seed 5 clears error, round-robin with both requesting
        bus.i_seed = 4'h5; bus.i_warmup = 8'd0; bus.i_start = 1'b1;
        step(0);
        bus.i_start = 1'b0;
        check_eq("t4_err_clear", bus.o_err, 0);
        check_eq("t4_lfsr_reset", lfsr_reset, 1);
        check_eq("t4_seed", lfsr_seed, 4'h5);
        step(0);
        bus.i_req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            fill_byte("t4", pats[k], pats[k]);
            check_eq("t4_rr_gnt", bus.o_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
            step(0);
            check_eq("t4_fill_gnt0", bus.o_gnt, 2'b00);
        end

        // Stop while a grant is pending in OFFER
        fill_byte("t5", 8'h96, 8'h96);
        bus.i_stop = 1'b1; #1;
        check_eq("t5_gnt_killed", bus.o_gnt, 2'b00);
        step(0);
        bus.i_stop = 1'b0; bus.i_req = 2'b00;
        check_eq("t5_valid", bus.o_valid, 0);
        check_eq("t5_busy", bus.o_busy, 0);

        // Reset on the 5th FILL edge, then a clean full byte
        bus.i_seed = 4'h3; bus.i_start = 1'b1;
        step(1);
        bus.i_start = 1'b0;
        step(1);
        for (int i = 0; i < 4; i++) step(1);
        rst = 1'b1;
        step(1);
        check_eq("t6_busy", bus.o_busy, 0);
        check_eq("t6_valid", bus.o_valid, 0);
        check_eq("t6_byte", bus.o_byte, 0);
        check_eq("t6_seed", lfsr_seed, 0);
        check_eq("t6_err", bus.o_err, 0);
        check_eq("t6_lfsr_reset", lfsr_reset, 0);
        rst = 1'b0;
        bus.i_seed = 4'h3; bus.i_start = 1'b1;
        step(1);
        bus.i_start = 1'b0;
        step(1);
        fill_byte("t6b", 8'h5A, 8'h5A);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
